md_issue_ctrl: RTL and testbench

Issue and stall controller that drives the multiply/divide unit (MDU) from the pipeline side. It takes the MD op class decoded in the D stage and registers it into the E stage. It generates the one-cycle `e_start` pulse for long-latency ops and keeps a shadow latency counter, so the pipeline can be stalled without the one-cycle gap before the MDU raises its busy flag. It also cross-checks the MDU's busy flag against its own prediction and flags any mismatch.

---
 rtl/md_issue_ctrl.sv | 80 ++++++++
 tb/tb_md_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// Issue/stall controller for the multiply/divide unit: registers the D-stage MD op into E,
// pulses e_start for long ops and shadows the MDU latency. Optional macro: MD_MSUB_EN (msub as long op).
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [3:0] d_op,
  input  logic       e_flush,
  input  logic       md_busy,
  output logic [3:0] e_op,
  output logic       e_start,
  output logic       stall,
  output logic       md_err
);

  localparam int CW = (DIV_CYCLES <= 15) ? 4 : $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          d_md;
  logic          d_long;
  logic          busy_eff;
  logic          issue;
  logic          e_mult_class;

  // Decode the D-stage op class; codes outside the table behave like "none".
  always_comb begin
    d_md   = 1'b0;
    d_long = 1'b0;
    case (d_op)
      4'd1, 4'd2, 4'd3, 4'd4: begin
        d_md   = 1'b1;
        d_long = 1'b1;
      end
      4'd5, 4'd6, 4'd7, 4'd8: d_md = 1'b1;
`ifdef MD_MSUB_EN
      4'd9: begin
        d_md   = 1'b1;
        d_long = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // MDU contract: e_start is a single-cycle request alongside e_op; the MDU raises md_busy
  // from the following cycle for exactly the op latency. e_start covers that first gap cycle.
  assign busy_eff     = e_start | (cnt != '0);
  assign stall        = d_valid & d_md & busy_eff;
  assign issue        = d_valid & d_md & ~e_flush & ~stall;
  assign e_mult_class = (e_op == 4'd1) | (e_op == 4'd2) | (e_op == 4'd9);

  always_comb begin
    cnt_next = cnt;
    if (e_start) begin
      cnt_next = e_mult_class ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (cnt != '0) begin
      cnt_next = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_op    <= 4'd0;
      e_start <= 1'b0;
      cnt     <= '0;
      md_err  <= 1'b0;
    end else begin
      e_op    <= issue ? d_op : 4'd0;
      e_start <= issue & d_long;
      // A flush only kills the incoming op; an in-flight MDU op keeps counting.
      cnt     <= cnt_next;
      md_err  <= md_err | (md_busy != (cnt != '0));
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small MDU model driving md_busy.
// Build with +define+MD_MSUB_EN to exercise msub as a long op.
module tb_md_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [3:0] d_op;
  logic       e_flush;
  logic       md_busy;
  logic [3:0] e_op;
  logic       e_start;
  logic       stall;
  logic       md_err;

  int n_checks;
  int n_fail;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_valid (d_valid),
    .d_op    (d_op),
    .e_flush (e_flush),
    .md_busy (md_busy),
    .e_op    (e_op),
    .e_start (e_start),
    .stall   (stall),
    .md_err  (md_err)
  );

  // MDU model: busy for the op latency starting the cycle after the start pulse.
  logic [3:0] mdu_cnt;
  logic       force_busy;
  always_ff @(posedge clk) begin
    if (reset) mdu_cnt <= 4'd0;
    else if (e_start) mdu_cnt <= (e_op == 4'd3 || e_op == 4'd4) ? 4'd10 : 4'd5;
    else if (mdu_cnt != 4'd0) mdu_cnt <= mdu_cnt - 4'd1;
  end
  assign md_busy = force_busy | (mdu_cnt != 4'd0);

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic fl);
    d_valid = v;
    d_op    = op;
    e_flush = fl;
    #1;
  endtask

  // Drive op every cycle until it is no longer stalled; returns the number of stalled cycles
  // and what E held in the first of those cycles.
  task automatic count_stall(input logic [3:0] op, output int n, output logic first_start,
                             output logic [3:0] first_op);
    n = 0;
    first_start = 1'b0;
    first_op = 4'd0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      drive(1'b1, op, 1'b0);
      if (i == 0) begin
        first_start = e_start;
        first_op = e_op;
      end
      if (!stall) break;
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  int         n;
  logic       fs;
  logic [3:0] fo;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    force_busy = 1'b0;
    do_reset();

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive(1'b0, 4'd0, 1'b0);
      check("idle_stall", stall, 0);
      check("idle_e_op", e_op, 0);
      check("idle_e_start", e_start, 0);
      check("idle_md_err", md_err, 0);
    end

    // mult at T, dependent mflo from T+1
    next_cycle();
    drive(1'b1, 4'd1, 1'b0);
    check("mult_T_stall", stall, 0);
    next_cycle();
    drive(1'b1, 4'd7, 1'b0);
    check("mult_T1_start", e_start, 1);
    check("mult_T1_e_op", e_op, 1);
    check("mult_T1_stall", stall, 1);
    for (int i = 2; i <= 6; i++) begin
      next_cycle();
      drive(1'b1, 4'd7, 1'b0);
      check("mult_window_stall", stall, 1);
      check("mult_window_start", e_start, 0);
      check("mult_window_e_op", e_op, 0);
    end
    next_cycle();
    drive(1'b1, 4'd7, 1'b0);
    check("mult_T7_stall", stall, 0);
    next_cycle();
    drive(1'b0, 4'd0, 1'b0);
    check("mflo_e_op", e_op, 7);
    check("mflo_e_start", e_start, 0);
    check("mult_md_err", md_err, 0);

    // div at T, multu stalled T+1..T+11, issued at T+12
    next_cycle();
    drive(1'b1, 4'd3, 1'b0);
    count_stall(4'd2, n, fs, fo);
    check("div_first_start", fs, 1);
    check("div_first_e_op", fo, 3);
    check("div_stall_len", n, 11);
    next_cycle();
    drive(1'b1, 4'd7, 1'b0);
    check("multu_start", e_start, 1);
    check("multu_e_op", e_op, 2);
    check("multu_stall_on_start", stall, 1);
    // Remaining window after the multu start shows the reload of 5
    count_stall(4'd7, n, fs, fo);
    check("multu_reload_len", n, 5);
    next_cycle();
    drive(1'b0, 4'd0, 1'b0);
    check("div_md_err", md_err, 0);

    // Unknown op code during a busy window: not stalled, not issued
    next_cycle();
    drive(1'b1, 4'd1, 1'b0);
    next_cycle();
    drive(1'b1, 4'd12, 1'b0);
    check("unknown_stall", stall, 0);
    next_cycle();
    drive(1'b0, 4'd0, 1'b0);
    check("unknown_e_op", e_op, 0);
    check("unknown_e_start", e_start, 0);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(1'b0, 4'd0, 1'b0);
    end

    // Flush while div sits in D
    next_cycle();
    drive(1'b1, 4'd3, 1'b1);
    next_cycle();
    drive(1'b1, 4'd6, 1'b0);
    check("flush_e_op", e_op, 0);
    check("flush_e_start", e_start, 0);
    check("flush_mthi_stall", stall, 0);
    next_cycle();
    drive(1'b1, 4'd7, 1'b0);
    check("mthi_e_op", e_op, 6);
    check("mthi_e_start", e_start, 0);
    check("flush_cnt_idle_stall", stall, 0);
    next_cycle();
    drive(1'b0, 4'd0, 1'b0);
    check("flush_md_err", md_err, 0);

    // Reset while cnt = 3 after a mult
    next_cycle();
    drive(1'b1, 4'd1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      drive(1'b0, 4'd0, 1'b0);
    end
    next_cycle();
    drive(1'b1, 4'd7, 1'b0);
    check("pre_reset_stall", stall, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 4'd7, 1'b0);
    check("post_reset_stall", stall, 0);
    check("post_reset_start", e_start, 0);
    next_cycle();
    drive(1'b0, 4'd0, 1'b0);
    check("post_reset_e_op", e_op, 7);
    check("post_reset_md_err", md_err, 0);

    // msub
`ifdef MD_MSUB_EN
    next_cycle();
    drive(1'b1, 4'd9, 1'b0);
    count_stall(4'd7, n, fs, fo);
    check("msub_start", fs, 1);
    check("msub_e_op", fo, 9);
    check("msub_stall_len", n, 6);
`else
    next_cycle();
    drive(1'b1, 4'd1, 1'b0);
    next_cycle();
    drive(1'b1, 4'd9, 1'b0);
    check("msub_off_stall", stall, 0);
    next_cycle();
    drive(1'b0, 4'd0, 1'b0);
    check("msub_off_e_op", e_op, 0);
    check("msub_off_start", e_start, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive(1'b0, 4'd0, 1'b0);
    end
    check("msub_md_err", md_err, 0);

    // Forced busy while idle sets the sticky error
    next_cycle();
    force_busy = 1'b1;
    next_cycle();
    force_busy = 1'b0;
    check("err_set", md_err, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("err_sticky", md_err, 1);
    end
    do_reset();
    next_cycle();
    check("err_cleared", md_err, 0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
